path_replay: RTL and testbench

- Downstream consumer of the solver datapath's replay stream (move_run).
- Accepts one 2-bit move per handshake and replays it on a square maze grid starting at (0,0).
- Tracks the current row/column with a parameterised pacing delay between steps, so a display or LED driver can animate the solved path.
- Reports completion, step count, and an out-of-bounds error if the stream would leave the grid.

---
 rtl/path_replay.sv | 163 ++++++++++++++++
 tb/tb_path_replay.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_replay.sv
// Replays a stream of 2-bit maze moves on a square grid starting at (0,0),
// holding each position for a programmable number of cycles so the path can be animated.
module path_replay #(
    parameter int GRID_BITS  = 4,
    parameter int STEP_DELAY = 4,
    parameter int MAX_STEPS  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 move_valid,
    input  logic [1:0]           move_run,
    input  logic                 move_last,
    output logic                 move_ready,
    output logic [GRID_BITS-1:0] row,
    output logic [GRID_BITS-1:0] col,
    output logic                 pos_valid,
    output logic [7:0]           step_count,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {IDLE, FETCH, HOLD, FINISH, ERROR} state_t;
    typedef enum logic [1:0] {
        MOVE_UP    = 2'b00,
        MOVE_RIGHT = 2'b01,
        MOVE_LEFT  = 2'b10,
        MOVE_DOWN  = 2'b11
    } move_t;

    localparam logic [GRID_BITS-1:0] COORD_MAX  = '1;
    localparam logic [GRID_BITS-1:0] COORD_ONE  = 1;
    localparam logic [7:0]           STEP_LIMIT = 8'(MAX_STEPS);
    // The pos_valid cycle is the first of the STEP_DELAY hold cycles, so count down to zero.
    localparam logic [7:0]           HOLD_LOAD  = 8'(STEP_DELAY - 1);

    state_t               state, state_next;
    logic [7:0]           delay_cnt;
    logic                 last_q;
    logic                 transfer;
    logic                 legal;
    logic [GRID_BITS-1:0] row_next, col_next;

    // Derived from state rather than move_ready to keep the FSM block free of feedback.
    assign transfer = move_valid && (state == FETCH);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        row_next = row;
        col_next = col;
        legal    = 1'b0;
        unique case (move_t'(move_run))
            MOVE_UP: begin
                legal    = (row != '0);
                row_next = row - COORD_ONE;
            end
            MOVE_RIGHT: begin
                legal    = (col != COORD_MAX);
                col_next = col + COORD_ONE;
            end
            MOVE_LEFT: begin
                legal    = (col != '0);
                col_next = col - COORD_ONE;
            end
            MOVE_DOWN: begin
                legal    = (row != COORD_MAX);
                row_next = row + COORD_ONE;
            end
        endcase
        if (step_count >= STEP_LIMIT) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        move_ready = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                move_ready = 1'b1;
                busy       = 1'b1;
                if (transfer) begin
                    state_next = legal ? HOLD : ERROR;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (delay_cnt == 8'd0) begin
                    state_next = last_q ? FINISH : FETCH;
                end
            end
            FINISH:  state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row        <= '0;
            col        <= '0;
            step_count <= '0;
            pos_valid  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            delay_cnt  <= '0;
            last_q     <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        row        <= '0;
                        col        <= '0;
                        step_count <= '0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                FETCH: begin
                    if (transfer) begin
                        if (legal) begin
                            row        <= row_next;
                            col        <= col_next;
                            step_count <= step_count + 8'd1;
                            pos_valid  <= 1'b1;
                            last_q     <= move_last;
                            delay_cnt  <= HOLD_LOAD;
                        end else begin
                            // An illegal move wins over move_last, so done is never set here.
                            err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (delay_cnt != 8'd0) begin
                        delay_cnt <= delay_cnt - 8'd1;
                    end else if (last_q) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_path_replay.sv
// Randomised and directed bench for path_replay; a grid-walk model predicts every position,
// step count, pacing interval and completion/error flag.
`timescale 1ns/1ps
module tb_path_replay;

    localparam int GRID_BITS  = 4;
    localparam int STEP_DELAY = 4;
    localparam int MAX_STEPS  = 255;
    localparam int GRID       = 1 << GRID_BITS;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 run = 1'b0;
    logic                 move_valid = 1'b0;
    logic [1:0]           move_run = 2'b00;
    logic                 move_last = 1'b0;
    logic                 move_ready;
    logic [GRID_BITS-1:0] row, col;
    logic                 pos_valid;
    logic [7:0]           step_count;
    logic                 busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pv_cnt = 0;
    int pv_base = 0;
    int exp_row, exp_col, exp_steps;
    logic [1:0] path[$];

    path_replay #(
        .GRID_BITS (GRID_BITS),
        .STEP_DELAY(STEP_DELAY),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .move_valid(move_valid),
        .move_run  (move_run),
        .move_last (move_last),
        .move_ready(move_ready),
        .row       (row),
        .col       (col),
        .pos_valid (pos_valid),
        .step_count(step_count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (pos_valid) pv_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic start_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        exp_row = 0;
        exp_col = 0;
        exp_steps = 0;
        pv_base = pv_cnt;
    endtask

    // Replays the global path. gap: idle cycles of move_valid before each later move;
    // run_at / abort_at: move index after which run is re-pulsed / rst is asserted (-1 = never).
    task automatic replay(input string name, input int gap, input int run_at, input int abort_at);
        int  last_t, waited, nr, nc, legal_cnt, idle_pre, space, exp_space;
        bit  legal, dead, aborted;
        dead = 1'b0; aborted = 1'b0; last_t = 0; legal_cnt = 0; idle_pre = 0;
        start_run();
        checks++;
        if (busy !== 1'b1 || move_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s start: busy=%b move_ready=%b, need 1/1", name, busy, move_ready);
        end
        for (int i = 0; i < path.size() && !dead; i++) begin
            if (gap > 0 && i > 0) begin
                move_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    checks++;
                    if (move_ready !== (cyc - last_t > STEP_DELAY) ||
                        row !== GRID_BITS'(exp_row) || col !== GRID_BITS'(exp_col)) begin
                        errors++;
                        $display("FAIL %s gap move %0d: ready=%b row=%0d col=%0d, need ready=%b row=%0d col=%0d",
                                 name, i, move_ready, row, col, (cyc - last_t > STEP_DELAY), exp_row, exp_col);
                    end
                    @(negedge clk);
                end
            end
            move_valid = 1'b1;
            move_run   = path[i];
            move_last  = (i == path.size() - 1);
            waited = 0;
            while (move_ready !== 1'b1 && waited < 4 * STEP_DELAY + 20) begin
                @(negedge clk);
                waited++;
            end
            if (move_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL %s move %0d: move_ready never rose after %0d cycles", name, i, waited);
                dead = 1'b1;
            end else begin
                if (i > 0) begin
                    space = cyc - last_t;
                    exp_space = (idle_pre + 1 > STEP_DELAY + 1) ? idle_pre + 1 : STEP_DELAY + 1;
                    checks++;
                    if (space != exp_space) begin
                        errors++;
                        $display("FAIL %s pacing move %0d: spacing=%0d cycles, need %0d", name, i, space, exp_space);
                    end
                end
                last_t = cyc;
                nr = exp_row;
                nc = exp_col;
                case (path[i])
                    2'b00:   nr = nr - 1;
                    2'b01:   nc = nc + 1;
                    2'b10:   nc = nc - 1;
                    default: nr = nr + 1;
                endcase
                legal = (nr >= 0) && (nr < GRID) && (nc >= 0) && (nc < GRID) && (exp_steps < MAX_STEPS);
                @(posedge clk);
                #1;
                if (legal) begin
                    exp_row = nr;
                    exp_col = nc;
                    exp_steps++;
                    legal_cnt++;
                end
                checks++;
                if (pos_valid !== legal || err !== !legal || row !== GRID_BITS'(exp_row) ||
                    col !== GRID_BITS'(exp_col) || step_count !== 8'(exp_steps)) begin
                    errors++;
                    $display("FAIL %s move %0d: pos_valid=%b err=%b row=%0d col=%0d steps=%0d, need %b %b %0d %0d %0d",
                             name, i, pos_valid, err, row, col, step_count, legal, !legal, exp_row, exp_col, exp_steps);
                end
                if (!legal) dead = 1'b1;
                @(negedge clk);
                move_valid = 1'b0;
                idle_pre = 0;
                if (i == abort_at) begin
                    rst = 1'b0;
                    @(posedge clk);
                    #1;
                    checks++;
                    if ({row, col, step_count, busy, done, err, pos_valid, move_ready} !== '0) begin
                        errors++;
                        $display("FAIL %s abort: row=%0d col=%0d steps=%0d busy=%b done=%b err=%b pv=%b rdy=%b, need all 0",
                                 name, row, col, step_count, busy, done, err, pos_valid, move_ready);
                    end
                    @(negedge clk);
                    rst = 1'b1;
                    dead = 1'b1;
                    aborted = 1'b1;
                end else if (i == run_at) begin
                    run = 1'b1;
                    @(negedge clk);
                    run = 1'b0;
                    idle_pre = 1;
                end
                if (gap > 0) idle_pre = gap;
            end
        end
        move_valid = 1'b0;
        move_last  = 1'b0;
        if (aborted) return;
        if (dead) begin
            repeat (3) @(negedge clk);
            checks++;
            if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || move_ready !== 1'b0 ||
                row !== GRID_BITS'(exp_row) || col !== GRID_BITS'(exp_col) || step_count !== 8'(exp_steps) ||
                pv_cnt - pv_base != legal_cnt) begin
                errors++;
                $display("FAIL %s error end: err=%b done=%b busy=%b rdy=%b row=%0d col=%0d steps=%0d pulses=%0d, need 1 0 0 0 %0d %0d %0d %0d",
                         name, err, done, busy, move_ready, row, col, step_count, pv_cnt - pv_base,
                         exp_row, exp_col, exp_steps, legal_cnt);
            end
        end else begin
            waited = 0;
            while (done !== 1'b1 && waited < STEP_DELAY + 10) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (done !== 1'b1 || waited > STEP_DELAY || err !== 1'b0 || busy !== 1'b0 ||
                row !== GRID_BITS'(exp_row) || col !== GRID_BITS'(exp_col) || step_count !== 8'(exp_steps) ||
                pv_cnt - pv_base != legal_cnt) begin
                errors++;
                $display("FAIL %s finish: done=%b after %0d cyc err=%b busy=%b row=%0d col=%0d steps=%0d pulses=%0d, need 1 within %0d, 0 0 %0d %0d %0d %0d",
                         name, done, waited, err, busy, row, col, step_count, pv_cnt - pv_base,
                         STEP_DELAY, exp_row, exp_col, exp_steps, legal_cnt);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || move_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s idle after finish: done=%b rdy=%b busy=%b, need 1 0 0", name, done, move_ready, busy);
            end
        end
    endtask

    task automatic test_reset();
        move_valid = 1'b1;
        move_run   = 2'b01;
        repeat (3) @(negedge clk);
        checks++;
        if ({row, col, step_count, move_ready, pos_valid, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset: row=%0d col=%0d steps=%0d rdy=%b pv=%b busy=%b done=%b err=%b, need all 0",
                     row, col, step_count, move_ready, pos_valid, busy, done, err);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (move_ready !== 1'b0 || busy !== 1'b0 || col !== '0 || pos_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle ignores moves: rdy=%b busy=%b col=%0d pv=%b, need 0 0 0 0", move_ready, busy, col, pos_valid);
        end
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || move_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset beats run: busy=%b rdy=%b, need 0 0", busy, move_ready);
        end
        move_valid = 1'b0;
    endtask

    task automatic test_basic_path();
        path = '{2'b01, 2'b01, 2'b11};
        replay("basic", 0, -1, -1);
        checks++;
        if (row !== 4'd1 || col !== 4'd2 || step_count !== 8'd3 || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic final: row=%0d col=%0d steps=%0d done=%b err=%b, need 1 2 3 1 0",
                     row, col, step_count, done, err);
        end
    endtask

    task automatic test_oob_up();
        path = '{2'b00};
        replay("oob_up", 0, -1, -1);
        checks++;
        if (row !== 4'd0 || col !== 4'd0 || step_count !== 8'd0 || err !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL oob_up final: row=%0d col=%0d steps=%0d err=%b done=%b, need 0 0 0 1 0",
                     row, col, step_count, err, done);
        end
    endtask

    task automatic test_right_edge();
        path = {};
        for (int i = 0; i < 16; i++) path.push_back(2'b01);
        replay("right_edge", 0, -1, -1);
        checks++;
        if (col !== 4'd15 || step_count !== 8'd15 || err !== 1'b1) begin
            errors++;
            $display("FAIL right_edge final: col=%0d steps=%0d err=%b, need 15 15 1", col, step_count, err);
        end
    endtask

    task automatic test_gaps();
        path = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b01};
        replay("gaps", 10, -1, -1);
    endtask

    task automatic test_run_while_busy();
        path = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b01};
        replay("run_busy", 0, 1, -1);
        checks++;
        if (step_count !== 8'd5 || row !== 4'd2 || col !== 4'd3) begin
            errors++;
            $display("FAIL run_busy final: steps=%0d row=%0d col=%0d, need 5 2 3", step_count, row, col);
        end
    endtask

    task automatic test_reset_mid();
        path = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01};
        replay("reset_mid", 0, -1, 2);
        path = '{2'b11, 2'b01};
        replay("after_reset", 0, -1, -1);
        checks++;
        if (row !== 4'd1 || col !== 4'd1 || step_count !== 8'd2) begin
            errors++;
            $display("FAIL after_reset final: row=%0d col=%0d steps=%0d, need 1 1 2", row, col, step_count);
        end
    endtask

    task automatic test_step_limit();
        path = {};
        for (int i = 0; i < MAX_STEPS; i++) path.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
        path.push_back(2'b01);
        replay("step_limit", 0, -1, -1);
        checks++;
        if (step_count !== 8'd255 || err !== 1'b1 || col !== 4'd1) begin
            errors++;
            $display("FAIL step_limit final: steps=%0d err=%b col=%0d, need 255 1 1", step_count, err, col);
        end
    endtask

    task automatic test_random();
        int len, gap;
        for (int r = 0; r < 10; r++) begin
            path = {};
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) < 7) path.push_back(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11);
                else path.push_back(2'($urandom_range(0, 3)));
            end
            gap = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 12);
            replay($sformatf("random%0d", r), gap, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_path();
        test_oob_up();
        test_right_edge();
        test_gaps();
        test_run_while_busy();
        test_reset_mid();
        test_step_limit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
